mem_access_stage: RTL and testbench

- Parametrised EX→MEM pipeline stage that sits between the execute stage and data memory.
- Registers pc+4, ALU result, store data and instruction.
- Decodes loads and stores into memory strobes (we/re), per-byte enables and lane-aligned write data.
- Adds valid/ready flow control with a 2-entry skid buffer, plus a synchronous flush for branch/trap squash.

---
 rtl/mem_access_stage.sv | 197 +++++++++++++++++++
 tb/tb_mem_access_stage.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// EX->MEM pipeline stage: registers the EX results, decodes loads/stores into byte lanes,
// and adds valid/ready flow control with a 2-entry skid buffer. Optional macro: MISALIGN_TRAP_EN.
module mem_access_stage #(
   parameter int XLEN = 32,
   parameter int BE_W = XLEN/8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_flush,
   input  logic            i_in_valid,
   output logic            o_in_ready,
   input  logic [XLEN-1:0] i_pc_exe,
   input  logic [XLEN-1:0] i_alu_out,
   input  logic [XLEN-1:0] i_data_b_exe,
   input  logic [31:0]     i_instr_exe,
   output logic            o_out_valid,
   input  logic            i_out_ready,
   output logic [XLEN-1:0] o_pc_4_acc,
   output logic [XLEN-1:0] o_alu_out_acc,
   output logic [XLEN-1:0] o_wdata_acc,
   output logic [BE_W-1:0] o_be_acc,
   output logic [31:0]     o_instr_acc,
   output logic            o_mem_we,
   output logic            o_mem_re,
   output logic            o_misalign
);

   localparam int         AW       = $clog2(BE_W);
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } size_e;

   typedef struct packed {
      logic [XLEN-1:0] pc4;
      logic [XLEN-1:0] alu;
      logic [XLEN-1:0] wdata;
      logic [BE_W-1:0] be;
      logic [31:0]     instr;
      logic            we;
      logic            re;
      logic            mis;
   } entry_t;

   function automatic entry_t decode(input logic [XLEN-1:0] pc,
                                     input logic [XLEN-1:0] alu,
                                     input logic [XLEN-1:0] data,
                                     input logic [31:0]     instr);
      entry_t          e;
      logic            legal;
      logic            is_st;
      logic            is_ld;
      size_e           sz;
      logic [AW-1:0]   lo;
      logic [AW-1:0]   low_mask;
      logic [BE_W-1:0] lane_mask;
      e         = '0;
      legal     = 1'b0;
      sz        = SZ_B;
      is_st     = (instr[6:0] == OP_STORE);
      is_ld     = (instr[6:0] == OP_LOAD);
      lo        = alu[AW-1:0];
      e.pc4     = pc + XLEN'(3'd4);
      e.alu     = alu;
      e.instr   = instr;
      if (is_st) begin
         case (instr[14:12])
            3'b000:  begin legal = 1'b1;         sz = SZ_B; end
            3'b001:  begin legal = 1'b1;         sz = SZ_H; end
            3'b010:  begin legal = 1'b1;         sz = SZ_W; end
            3'b011:  begin legal = (XLEN == 64); sz = SZ_D; end
            default: begin legal = 1'b0;         sz = SZ_B; end
         endcase
      end else if (is_ld) begin
         case (instr[14:12])
            3'b000, 3'b100: begin legal = 1'b1;         sz = SZ_B; end
            3'b001, 3'b101: begin legal = 1'b1;         sz = SZ_H; end
            3'b010:         begin legal = 1'b1;         sz = SZ_W; end
            3'b110:         begin legal = (XLEN == 64); sz = SZ_W; end
            3'b011:         begin legal = (XLEN == 64); sz = SZ_D; end
            default:        begin legal = 1'b0;         sz = SZ_B; end
         endcase
      end else begin
         legal = 1'b0;
      end
      // lane_mask covers the access width; low_mask selects address bits below the access size
      case (sz)
         SZ_B: begin
            lane_mask = BE_W'(1'b1);
            low_mask  = '0;
            e.wdata   = {BE_W{data[7:0]}};
         end
         SZ_H: begin
            lane_mask = BE_W'(2'b11);
            low_mask  = AW'(1'b1);
            e.wdata   = {(BE_W/2){data[15:0]}};
         end
         SZ_W: begin
            lane_mask = BE_W'(4'hF);
            low_mask  = AW'(2'd3);
            e.wdata   = {(XLEN/32){data[31:0]}};
         end
         default: begin
            lane_mask = '1;
            low_mask  = AW'(3'd7);
            e.wdata   = data;
         end
      endcase
      if (legal) begin
         e.be = lane_mask << (lo & ~low_mask);
         e.we = is_st;
         e.re = is_ld;
      end else begin
         e.be    = '0;
         e.we    = 1'b0;
         e.re    = 1'b0;
         e.wdata = data;
      end
`ifdef MISALIGN_TRAP_EN
      e.mis = legal & (|(lo & low_mask));
      if (e.mis) begin
         e.be = '0;
         e.we = 1'b0;
         e.re = 1'b0;
      end else begin
         e.be = e.be;
      end
`else
      e.mis = 1'b0;
`endif
      return e;
   endfunction

   entry_t r_out;
   entry_t r_skid;
   logic   r_out_valid;
   logic   r_skid_valid;
   logic   r_in_ready;
   entry_t w_dec;
   logic   w_accept;
   logic   w_out_load;

   // Decode the EX instruction and derive the handshake qualifiers.
   always_comb begin
      w_dec      = decode(i_pc_exe, i_alu_out, i_data_b_exe, i_instr_exe);
      w_accept   = i_in_valid & r_in_ready;
      w_out_load = ~r_out_valid | i_out_ready;
   end

   // Output register and skid entry; the skid only fills while the output is stalled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out        <= '0;
         r_skid       <= '0;
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
         r_in_ready   <= 1'b1;
      end else if (i_flush) begin
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
         r_in_ready   <= 1'b1;
      end else if (w_out_load) begin
         if (r_skid_valid) begin
            r_out       <= r_skid;
            r_out_valid <= 1'b1;
         end else if (w_accept) begin
            r_out       <= w_dec;
            r_out_valid <= 1'b1;
         end else begin
            r_out_valid <= 1'b0;
         end
         r_skid_valid <= 1'b0;
         r_in_ready   <= 1'b1;
      end else if (w_accept) begin
         r_skid       <= w_dec;
         r_skid_valid <= 1'b1;
         r_in_ready   <= 1'b0;
      end
   end

   assign o_in_ready    = r_in_ready;
   assign o_out_valid   = r_out_valid;
   assign o_pc_4_acc    = r_out.pc4;
   assign o_alu_out_acc = r_out.alu;
   assign o_wdata_acc   = r_out.wdata;
   assign o_be_acc      = r_out.be;
   assign o_instr_acc   = r_out.instr;
   assign o_mem_we      = r_out_valid & r_out.we;
   assign o_mem_re      = r_out_valid & r_out.re;
   assign o_misalign    = r_out_valid & r_out.mis;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomised bench for mem_access_stage: a queue of held entries models occupancy and FIFO order,
// and an arithmetic decode model predicts every output field.
module tb_mem_access_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_flush, i_in_valid, i_out_ready;
   logic [31:0] i_pc_exe, i_alu_out, i_data_b_exe, i_instr_exe;
   logic        o_in_ready, o_out_valid, o_mem_we, o_mem_re, o_misalign;
   logic [31:0] o_pc_4_acc, o_alu_out_acc, o_wdata_acc, o_instr_acc;
   logic [3:0]  o_be_acc;

   logic        i_in_valid_64;
   logic [63:0] i_pc_64, i_alu_64, i_data_64;
   logic [31:0] i_instr_64;
   logic        o_in_ready_64, o_out_valid_64, o_mem_we_64, o_mem_re_64, o_misalign_64;
   logic [63:0] o_pc_4_64, o_alu_64, o_wdata_64;
   logic [31:0] o_instr_64;
   logic [7:0]  o_be_64;

   mem_access_stage #(.XLEN(32)) dut (
      .clk(clk), .rst(rst), .i_flush(i_flush), .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
      .i_pc_exe(i_pc_exe), .i_alu_out(i_alu_out), .i_data_b_exe(i_data_b_exe), .i_instr_exe(i_instr_exe),
      .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_pc_4_acc(o_pc_4_acc),
      .o_alu_out_acc(o_alu_out_acc), .o_wdata_acc(o_wdata_acc), .o_be_acc(o_be_acc),
      .o_instr_acc(o_instr_acc), .o_mem_we(o_mem_we), .o_mem_re(o_mem_re), .o_misalign(o_misalign)
   );

   mem_access_stage #(.XLEN(64)) dut64 (
      .clk(clk), .rst(rst), .i_flush(1'b0), .i_in_valid(i_in_valid_64), .o_in_ready(o_in_ready_64),
      .i_pc_exe(i_pc_64), .i_alu_out(i_alu_64), .i_data_b_exe(i_data_64), .i_instr_exe(i_instr_64),
      .o_out_valid(o_out_valid_64), .i_out_ready(1'b1), .o_pc_4_acc(o_pc_4_64),
      .o_alu_out_acc(o_alu_64), .o_wdata_acc(o_wdata_64), .o_be_acc(o_be_64),
      .o_instr_acc(o_instr_64), .o_mem_we(o_mem_we_64), .o_mem_re(o_mem_re_64), .o_misalign(o_misalign_64)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] pc4, alu, wdata;
      logic [7:0]  be;
      logic [31:0] instr;
      logic        we, re, mis;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic exp_t model_decode(input int xl, input logic [63:0] pc, input logic [63:0] alu,
                                         input logic [63:0] data, input logic [31:0] instr);
      exp_t        e;
      int          nb, n, ofs, f3;
      logic [63:0] mask;
      nb      = xl / 8;
      mask    = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      f3      = int'(instr[14:12]);
      n       = 0;
      e.pc4   = (pc + 64'd4) & mask;
      e.alu   = alu & mask;
      e.instr = instr;
      e.wdata = data & mask;
      e.be    = 8'd0;
      e.we    = 1'b0;
      e.re    = 1'b0;
      e.mis   = 1'b0;
      if (instr[6:0] == 7'b0100011) begin
         case (f3)
            0: n = 1;
            1: n = 2;
            2: n = 4;
            3: n = (xl == 64) ? 8 : 0;
            default: n = 0;
         endcase
         e.we = (n != 0);
      end else if (instr[6:0] == 7'b0000011) begin
         case (f3)
            0, 4: n = 1;
            1, 5: n = 2;
            2: n = 4;
            6: n = (xl == 64) ? 4 : 0;
            3: n = (xl == 64) ? 8 : 0;
            default: n = 0;
         endcase
         e.re = (n != 0);
      end
      if (n != 0) begin
         ofs  = int'(alu[2:0]) % nb;
         e.be = 8'(((1 << n) - 1) << (ofs - ofs % n));
         for (int i = 0; i < nb; i++) e.wdata[8*i +: 8] = data[8*(i % n) +: 8];
`ifdef MISALIGN_TRAP_EN
         if (ofs % n != 0) begin
            e.mis = 1'b1;
            e.we  = 1'b0;
            e.re  = 1'b0;
            e.be  = 8'd0;
         end
`endif
      end
      return e;
   endfunction

   function automatic logic [31:0] mk(input logic [6:0] op, input logic [2:0] f3);
      return {17'($urandom), f3, 5'($urandom), op};
   endfunction

   task automatic check_outputs();
      exp_t h;
      check_eq("out_valid", o_out_valid, q.size() > 0);
      check_eq("in_ready", o_in_ready, q.size() < 2);
      if (q.size() > 0) begin
         h = q[0];
         check_eq("pc_4_acc", o_pc_4_acc, h.pc4);
         check_eq("alu_out_acc", o_alu_out_acc, h.alu);
         check_eq("wdata_acc", o_wdata_acc, h.wdata);
         check_eq("be_acc", o_be_acc, h.be);
         check_eq("instr_acc", o_instr_acc, h.instr);
         check_eq("mem_we", o_mem_we, h.we);
         check_eq("mem_re", o_mem_re, h.re);
         check_eq("misalign", o_misalign, h.mis);
      end else begin
         check_eq("idle_we", o_mem_we, 1'b0);
         check_eq("idle_re", o_mem_re, 1'b0);
      end
   endtask

   // Drive one cycle of stimulus, advance the model to the post-edge state, then check at the next negedge.
   task automatic cycle(input logic v, input logic rdy, input logic fl, input logic [31:0] pc,
                        input logic [31:0] alu, input logic [31:0] data, input logic [31:0] instr);
      logic model_ready;
      i_in_valid   = v;
      i_out_ready  = rdy;
      i_flush      = fl;
      i_pc_exe     = pc;
      i_alu_out    = alu;
      i_data_b_exe = data;
      i_instr_exe  = instr;
      model_ready  = (q.size() < 2);
      if (fl) begin
         q.delete();
      end else begin
         if (q.size() > 0 && rdy) void'(q.pop_front());
         if (v && model_ready) q.push_back(model_decode(32, {32'd0, pc}, {32'd0, alu}, {32'd0, data}, instr));
      end
      @(negedge clk);
      check_outputs();
   endtask

   initial begin
      exp_t        e64;
      logic [6:0]  op;
      logic [31:0] ins;
      rst = 1'b1;
      i_flush = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b0;
      i_pc_exe = 32'd0; i_alu_out = 32'd0; i_data_b_exe = 32'd0; i_instr_exe = 32'd0;
      i_in_valid_64 = 1'b0; i_pc_64 = 64'd0; i_alu_64 = 64'd0; i_data_64 = 64'd0; i_instr_64 = 32'd0;
      repeat (2) @(negedge clk);
      check_eq("rst_out_valid", o_out_valid, 1'b0);
      check_eq("rst_in_ready", o_in_ready, 1'b1);
      check_eq("rst_mem_we", o_mem_we, 1'b0);
      check_eq("rst_mem_re", o_mem_re, 1'b0);
      check_eq("rst_be", o_be_acc, 4'd0);
      check_eq("rst_misalign", o_misalign, 1'b0);
      check_eq("rst_pc4", o_pc_4_acc, 32'd0);
      check_eq("rst_wdata", o_wdata_acc, 32'd0);
      rst = 1'b0;

      // SB to byte lane 2
      cycle(1'b1, 1'b1, 1'b0, 32'h100, 32'h1002, 32'h0000_00AB, mk(7'b0100011, 3'b000));
      check_eq("sb_we", o_mem_we, 1'b1);
      check_eq("sb_be", o_be_acc, 4'b0100);
      check_eq("sb_wdata", o_wdata_acc, 32'hABAB_ABAB);
      check_eq("sb_pc4", o_pc_4_acc, 32'h104);

      // ADD with PC wrap
      cycle(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h1234, 32'h5678, 32'h0020_8033);
      check_eq("wrap_pc4", o_pc_4_acc, 32'd0);
      check_eq("add_we", o_mem_we, 1'b0);
      check_eq("add_re", o_mem_re, 1'b0);
      check_eq("add_be", o_be_acc, 4'd0);

      // Three back-to-back LW against a stalled consumer
      cycle(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
      cycle(1'b1, 1'b0, 1'b0, 32'h200, 32'h3000, 32'h1, mk(7'b0000011, 3'b010));
      cycle(1'b1, 1'b0, 1'b0, 32'h204, 32'h3004, 32'h2, mk(7'b0000011, 3'b010));
      check_eq("lw_stall_in_ready", o_in_ready, 1'b0);
      ins = mk(7'b0000011, 3'b010);
      cycle(1'b1, 1'b1, 1'b0, 32'h208, 32'h3008, 32'h3, ins);
      cycle(1'b1, 1'b1, 1'b0, 32'h208, 32'h3008, 32'h3, ins);
      repeat (3) cycle(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);

      // Flush with skid full and a new input presented
      cycle(1'b1, 1'b0, 1'b0, 32'h300, 32'h4000, 32'h11, mk(7'b0000011, 3'b010));
      cycle(1'b1, 1'b0, 1'b0, 32'h304, 32'h4004, 32'h22, mk(7'b0100011, 3'b010));
      cycle(1'b1, 1'b0, 1'b1, 32'h308, 32'h4008, 32'h33, mk(7'b0100011, 3'b010));
      check_eq("flush_out_valid", o_out_valid, 1'b0);
      check_eq("flush_in_ready", o_in_ready, 1'b1);
      check_eq("flush_we", o_mem_we, 1'b0);
      cycle(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
      check_eq("flush_dropped", o_out_valid, 1'b0);

      // LH at an odd address, then SW at an unaligned address
      cycle(1'b1, 1'b1, 1'b0, 32'h400, 32'h2001, 32'h0, mk(7'b0000011, 3'b001));
`ifdef MISALIGN_TRAP_EN
      check_eq("lh_misalign", o_misalign, 1'b1);
      check_eq("lh_re", o_mem_re, 1'b0);
      check_eq("lh_be", o_be_acc, 4'd0);
`else
      check_eq("lh_misalign", o_misalign, 1'b0);
      check_eq("lh_re", o_mem_re, 1'b1);
      check_eq("lh_be", o_be_acc, 4'b0011);
`endif
      cycle(1'b1, 1'b1, 1'b0, 32'h404, 32'h1003, 32'hDEAD_BEEF, mk(7'b0100011, 3'b010));
`ifndef MISALIGN_TRAP_EN
      check_eq("sw_unaligned_be", o_be_acc, 4'hF);
      check_eq("sw_unaligned_we", o_mem_we, 1'b1);
`endif

      // Random traffic
      for (int k = 0; k < 600; k++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: op = 7'b0100011;
            4, 5, 6, 7: op = 7'b0000011;
            8:          op = 7'b0110011;
            default:    op = 7'($urandom);
         endcase
         cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0,
               $urandom, $urandom, $urandom, mk(op, 3'($urandom)));
      end

      // Asynchronous reset while stalled with both entries held
      cycle(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
      cycle(1'b1, 1'b0, 1'b0, 32'h500, 32'h6000, 32'h5, mk(7'b0100011, 3'b000));
      cycle(1'b1, 1'b0, 1'b0, 32'h504, 32'h6001, 32'h6, mk(7'b0100011, 3'b000));
      #2 rst = 1'b1;
      #1;
      check_eq("async_rst_out_valid", o_out_valid, 1'b0);
      check_eq("async_rst_in_ready", o_in_ready, 1'b1);
      check_eq("async_rst_we", o_mem_we, 1'b0);
      q.delete();
      @(negedge clk);
      rst = 1'b0;
      cycle(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);

      // 64-bit instance: SD and LWU
      i_in_valid_64 = 1'b1;
      i_pc_64 = 64'h0000_0001_0000_0000; i_alu_64 = 64'h10; i_data_64 = 64'h1122_3344_5566_7788;
      i_instr_64 = mk(7'b0100011, 3'b011);
      e64 = model_decode(64, i_pc_64, i_alu_64, i_data_64, i_instr_64);
      cycle(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
      i_in_valid_64 = 1'b0;
      check_eq("sd_valid", o_out_valid_64, 1'b1);
      check_eq("sd_be", o_be_64, 8'hFF);
      check_eq("sd_we", o_mem_we_64, 1'b1);
      check_eq("sd_wdata", o_wdata_64, e64.wdata);
      check_eq("sd_pc4", o_pc_4_64, e64.pc4);
      i_in_valid_64 = 1'b1;
      i_alu_64 = 64'h14; i_data_64 = 64'h0000_0000_CAFE_F00D;
      i_instr_64 = mk(7'b0000011, 3'b110);
      e64 = model_decode(64, i_pc_64, i_alu_64, i_data_64, i_instr_64);
      cycle(1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
      i_in_valid_64 = 1'b0;
      check_eq("lwu_be", o_be_64, 8'hF0);
      check_eq("lwu_re", o_mem_re_64, 1'b1);
      check_eq("lwu_we", o_mem_we_64, 1'b0);
      check_eq("lwu_be_model", o_be_64, e64.be);
      check_eq("lwu_wdata", o_wdata_64, e64.wdata);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
